// File: rtl/draw_pkg.sv
// Shared constants for the rectangle draw datapath: command codes, colours,
// screen and object geometry, and the two-state draw FSM encoding.
package draw_pkg;

    localparam int SCREEN_W      = 160;
    localparam int SCREEN_H      = 120;
    localparam int BRICK_W       = 36;
    localparam int BRICK_H       = 6;
    localparam int BRICK_X0      = 4;
    localparam int BRICK_Y0      = 8;
    localparam int BRICK_PITCH_X = 39;
    localparam int BRICK_PITCH_Y = 10;
    localparam int PADDLE_W      = 24;
    localparam int PADDLE_H      = 3;
    localparam int PADDLE_Y      = 112;
    localparam int BALL_SZ       = 2;

    localparam logic [4:0] DRAW_NONE         = 5'd0;
    localparam logic [4:0] DRAW_POP_FIRST    = 5'd1;
    localparam logic [4:0] DRAW_POP_LAST     = 5'd12;
    localparam logic [4:0] DRAW_ERASE_PADDLE = 5'd13;
    localparam logic [4:0] DRAW_PADDLE       = 5'd14;
    localparam logic [4:0] DRAW_ERASE_BALL   = 5'd15;
    localparam logic [4:0] DRAW_BALL         = 5'd16;
    localparam logic [4:0] DRAW_REMOVE_FIRST = 5'd17;
    localparam logic [4:0] DRAW_REMOVE_LAST  = 5'd28;

    localparam logic [2:0] C_BLACK  = 3'b000;
    localparam logic [2:0] C_RED    = 3'b100;
    localparam logic [2:0] C_YELLOW = 3'b110;
    localparam logic [2:0] C_GREEN  = 3'b010;
    localparam logic [2:0] C_WHITE  = 3'b111;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    function automatic logic [2:0] brick_colour(input logic [1:0] row);
        case (row)
            2'd0:    return C_RED;
            2'd1:    return C_YELLOW;
            default: return C_GREEN;
        endcase
    endfunction

endpackage

// File: rtl/rect_geometry_lut.sv
// Combinational decode of a draw command into rectangle origin, size and colour.
module rect_geometry_lut
    import draw_pkg::*;
(
    input  logic [4:0] code_i,
    input  logic [7:0] paddle_x_i,
    input  logic [7:0] paddle_x_old_i,
    input  logic [7:0] ball_x_i,
    input  logic [6:0] ball_y_i,
    input  logic [7:0] ball_x_old_i,
    input  logic [6:0] ball_y_old_i,
    output logic [7:0] x0_o,
    output logic [6:0] y0_o,
    output logic [5:0] w_o,
    output logic [2:0] h_o,
    output logic [2:0] colour_o,
    output logic       valid_o
);

    logic [3:0] idx;
    logic       brick;

    always_comb begin
        x0_o     = '0;
        y0_o     = '0;
        w_o      = '0;
        h_o      = '0;
        colour_o = C_BLACK;
        valid_o  = 1'b0;
        idx      = '0;
        brick    = 1'b0;

        if (code_i >= DRAW_POP_FIRST && code_i <= DRAW_POP_LAST) begin
            idx      = 4'(code_i - DRAW_POP_FIRST);
            brick    = 1'b1;
            colour_o = brick_colour(idx[3:2]);
        end else if (code_i >= DRAW_REMOVE_FIRST && code_i <= DRAW_REMOVE_LAST) begin
            idx      = 4'(code_i - DRAW_REMOVE_FIRST);
            brick    = 1'b1;
            colour_o = C_BLACK;
        end

        // Brick index: low two bits select the column, upper two the row.
        if (brick) begin
            x0_o    = 8'(BRICK_X0) + 8'(BRICK_PITCH_X) * {6'd0, idx[1:0]};
            y0_o    = 7'(BRICK_Y0) + 7'(BRICK_PITCH_Y) * {5'd0, idx[3:2]};
            w_o     = 6'(BRICK_W);
            h_o     = 3'(BRICK_H);
            valid_o = 1'b1;
        end

        case (code_i)
            DRAW_ERASE_PADDLE: begin
                x0_o = paddle_x_old_i; y0_o = 7'(PADDLE_Y);
                w_o  = 6'(PADDLE_W);   h_o  = 3'(PADDLE_H);
                colour_o = C_BLACK;    valid_o = 1'b1;
            end
            DRAW_PADDLE: begin
                x0_o = paddle_x_i;     y0_o = 7'(PADDLE_Y);
                w_o  = 6'(PADDLE_W);   h_o  = 3'(PADDLE_H);
                colour_o = C_WHITE;    valid_o = 1'b1;
            end
            DRAW_ERASE_BALL: begin
                x0_o = ball_x_old_i;   y0_o = ball_y_old_i;
                w_o  = 6'(BALL_SZ);    h_o  = 3'(BALL_SZ);
                colour_o = C_BLACK;    valid_o = 1'b1;
            end
            DRAW_BALL: begin
                x0_o = ball_x_i;       y0_o = ball_y_i;
                w_o  = 6'(BALL_SZ);    h_o  = 3'(BALL_SZ);
                colour_o = C_WHITE;    valid_o = 1'b1;
            end
            DRAW_NONE: valid_o = 1'b0;
            default: ;
        endcase
    end

endmodule

// File: rtl/rect_draw_engine.sv
// Rectangle draw engine: latches a decoded command, then scans it one pixel per
// clock into registered VGA outputs, clipping anything outside the screen.
//   state  | meaning
//   S_IDLE | waiting for a valid command; busy follows the command's validity
//   S_RUN  | scanning cx (inner) and cy (outer) over the latched rectangle
module rect_draw_engine
    import draw_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] ld_draw,
    input  logic [7:0] paddle_x,
    input  logic [7:0] paddle_x_old,
    input  logic [7:0] ball_x,
    input  logic [6:0] ball_y,
    input  logic [7:0] ball_x_old,
    input  logic [6:0] ball_y_old,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy,
    output logic       done
);

    state_t     state_q, state_d;
    logic [4:0] code_q, code_d;
    logic [7:0] x0_q, x0_d;
    logic [6:0] y0_q, y0_d;
    logic [5:0] w_q, w_d;
    logic [2:0] h_q, h_d;
    logic [2:0] col_q, col_d;
    logic [5:0] cx_q, cx_d;
    logic [2:0] cy_q, cy_d;
    logic [7:0] x_q, x_d;
    logic [6:0] y_q, y_d;
    logic [2:0] colour_q, colour_d;
    logic       plot_q, plot_d;
    logic       done_q, done_d;

    logic [7:0] geo_x0;
    logic [6:0] geo_y0;
    logic [5:0] geo_w;
    logic [2:0] geo_h;
    logic [2:0] geo_colour;
    logic       geo_valid;
    logic [8:0] xs;
    logic [7:0] ys;
    logic       last_px;

    rect_geometry_lut u_lut (
        .code_i         (ld_draw),
        .paddle_x_i     (paddle_x),
        .paddle_x_old_i (paddle_x_old),
        .ball_x_i       (ball_x),
        .ball_y_i       (ball_y),
        .ball_x_old_i   (ball_x_old),
        .ball_y_old_i   (ball_y_old),
        .x0_o           (geo_x0),
        .y0_o           (geo_y0),
        .w_o            (geo_w),
        .h_o            (geo_h),
        .colour_o       (geo_colour),
        .valid_o        (geo_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            code_q   <= '0;
            x0_q     <= '0;
            y0_q     <= '0;
            w_q      <= '0;
            h_q      <= '0;
            col_q    <= '0;
            cx_q     <= '0;
            cy_q     <= '0;
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
            plot_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            code_q   <= code_d;
            x0_q     <= x0_d;
            y0_q     <= y0_d;
            w_q      <= w_d;
            h_q      <= h_d;
            col_q    <= col_d;
            cx_q     <= cx_d;
            cy_q     <= cy_d;
            x_q      <= x_d;
            y_q      <= y_d;
            colour_q <= colour_d;
            plot_q   <= plot_d;
            done_q   <= done_d;
        end
    end

    // Widened sums so off-screen pixels clip rather than wrap onto column 0.
    assign xs      = {1'b0, x0_q} + {3'b000, cx_q};
    assign ys      = {1'b0, y0_q} + {5'b00000, cy_q};
    assign last_px = (cx_q == w_q - 6'd1) && (cy_q == h_q - 3'd1);

    always_comb begin
        state_d  = state_q;
        code_d   = code_q;
        x0_d     = x0_q;
        y0_d     = y0_q;
        w_d      = w_q;
        h_d      = h_q;
        col_d    = col_q;
        cx_d     = cx_q;
        cy_d     = cy_q;
        x_d      = x_q;
        y_d      = y_q;
        colour_d = colour_q;
        plot_d   = 1'b0;
        done_d   = 1'b0;
        busy     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (geo_valid) begin
                    busy    = 1'b1;
                    code_d  = ld_draw;
                    x0_d    = geo_x0;
                    y0_d    = geo_y0;
                    w_d     = geo_w;
                    h_d     = geo_h;
                    col_d   = geo_colour;
                    cx_d    = '0;
                    cy_d    = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // Command withdrawn or changed: drop the rectangle without a done.
                if (ld_draw != code_q) begin
                    state_d = S_IDLE;
                end else begin
                    x_d      = xs[7:0];
                    y_d      = ys[6:0];
                    colour_d = col_q;
                    plot_d   = (xs < 9'(SCREEN_W)) && (ys < 8'(SCREEN_H));
                    if (last_px) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        busy = 1'b1;
                        if (cx_q == w_q - 6'd1) begin
                            cx_d = '0;
                            cy_d = cy_q + 3'd1;
                        end else begin
                            cx_d = cx_q + 6'd1;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign x      = x_q;
    assign y      = y_q;
    assign colour = colour_q;
    assign plot   = plot_q;
    assign done   = done_q;

endmodule

// File: tb/tb_rect_draw_engine.sv
// Directed bench for rect_draw_engine: bricks, back-to-back, clipping, abort, no-ops, reset.
module tb_rect_draw_engine;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] ld_draw;
    logic [7:0] paddle_x, paddle_x_old, ball_x, ball_x_old;
    logic [6:0] ball_y, ball_y_old;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot, busy, done;

    int n_run  = 0;
    int n_fail = 0;

    int         s_busy, s_plot, s_done, s_first_idx;
    logic [7:0] s_fx, s_lx, s_minx, s_maxx;
    logic [6:0] s_fy, s_ly, s_miny, s_maxy;
    logic [2:0] s_fcol;
    bit         s_mixcol, s_timeout;

    always #5 clk = ~clk;

    rect_draw_engine dut (
        .clk          (clk),
        .reset        (reset),
        .ld_draw      (ld_draw),
        .paddle_x     (paddle_x),
        .paddle_x_old (paddle_x_old),
        .ball_x       (ball_x),
        .ball_y       (ball_y),
        .ball_x_old   (ball_x_old),
        .ball_y_old   (ball_y_old),
        .x            (x),
        .y            (y),
        .colour       (colour),
        .plot         (plot),
        .busy         (busy),
        .done         (done)
    );

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Holds code until busy is seen low, then returns just after the following
    // edge (the idle cycle), so a caller can issue the next code with no bubble.
    task automatic run_cmd(input logic [4:0] code, input int max_cyc);
        logic b;
        int   idx;
        s_busy = 0; s_plot = 0; s_done = 0; s_first_idx = 0;
        s_minx = 8'hff; s_maxx = 8'h00; s_miny = 7'h7f; s_maxy = 7'h00;
        s_fx = 0; s_fy = 0; s_lx = 0; s_ly = 0; s_fcol = 0;
        s_mixcol = 0; s_timeout = 1;
        idx = 0;
        ld_draw = code;
        for (int i = 0; i < max_cyc; i++) begin
            #1;
            b = busy;
            if (b) s_busy++;
            @(posedge clk);
            #1;
            idx++;
            if (plot) begin
                if (s_plot == 0) begin
                    s_fx = x; s_fy = y; s_fcol = colour; s_first_idx = idx;
                end else if (colour !== s_fcol) begin
                    s_mixcol = 1;
                end
                s_plot++;
                s_lx = x; s_ly = y;
                if (x < s_minx) s_minx = x;
                if (x > s_maxx) s_maxx = x;
                if (y < s_miny) s_miny = y;
                if (y > s_maxy) s_maxy = y;
            end
            if (done) s_done++;
            if (!b) begin
                s_timeout = 0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1; ld_draw = 0;
        paddle_x = 0; paddle_x_old = 0; ball_x = 0; ball_y = 0; ball_x_old = 0; ball_y_old = 0;
        cycle(); cycle();
        #1;
        n_run++; if (plot !== 1'b0) begin n_fail++; $display("FAIL reset_plot: got %0b want 0", plot); end
        n_run++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b want 0", busy); end
        n_run++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0b want 0", done); end
        n_run++; if (x !== 8'd0) begin n_fail++; $display("FAIL reset_x: got %0d want 0", x); end
        n_run++; if (y !== 7'd0) begin n_fail++; $display("FAIL reset_y: got %0d want 0", y); end
        reset = 0;
        cycle();
    endtask

    task automatic test_brick1();
        run_cmd(5'd1, 400);
        ld_draw = 0;
        n_run++; if (s_timeout) begin n_fail++; $display("FAIL b1_timeout: busy never fell within 400 cycles"); end
        n_run++; if (s_busy != 216) begin n_fail++; $display("FAIL b1_busy_cycles: got %0d want 216", s_busy); end
        n_run++; if (s_plot != 216) begin n_fail++; $display("FAIL b1_plots: got %0d want 216", s_plot); end
        n_run++; if (s_fx !== 8'd4 || s_fy !== 7'd8) begin n_fail++; $display("FAIL b1_first: got (%0d,%0d) want (4,8)", s_fx, s_fy); end
        n_run++; if (s_fcol !== 3'b100 || s_mixcol) begin n_fail++; $display("FAIL b1_colour: got %b mixed=%0b want 100", s_fcol, s_mixcol); end
        n_run++; if (s_lx !== 8'd39 || s_ly !== 7'd13) begin n_fail++; $display("FAIL b1_last: got (%0d,%0d) want (39,13)", s_lx, s_ly); end
        n_run++; if (s_done != 1) begin n_fail++; $display("FAIL b1_done_count: got %0d want 1", s_done); end
        cycle();
        n_run++; if (done !== 1'b0 || plot !== 1'b0) begin n_fail++; $display("FAIL b1_after: done=%0b plot=%0b want 0 0", done, plot); end
    endtask

    task automatic test_back_to_back();
        int         p12;
        logic [7:0] minx12, maxx12;
        logic [6:0] miny12, maxy12;
        logic [2:0] col12;
        bit         mix12;
        paddle_x_old = 8'd50;
        run_cmd(5'd12, 400);
        p12 = s_plot; minx12 = s_minx; maxx12 = s_maxx; miny12 = s_miny; maxy12 = s_maxy;
        col12 = s_fcol; mix12 = s_mixcol;
        run_cmd(5'd13, 200);
        ld_draw = 0;
        n_run++; if (p12 != 216) begin n_fail++; $display("FAIL b12_plots: got %0d want 216", p12); end
        n_run++; if (minx12 !== 8'd121 || maxx12 !== 8'd156) begin n_fail++; $display("FAIL b12_xspan: got %0d..%0d want 121..156", minx12, maxx12); end
        n_run++; if (miny12 !== 7'd28 || maxy12 !== 7'd33) begin n_fail++; $display("FAIL b12_yspan: got %0d..%0d want 28..33", miny12, maxy12); end
        n_run++; if (col12 !== 3'b010 || mix12) begin n_fail++; $display("FAIL b12_colour: got %b mixed=%0b want 010", col12, mix12); end
        n_run++; if (s_timeout || s_busy != 72) begin n_fail++; $display("FAIL pe_busy_cycles: got %0d timeout=%0b want 72", s_busy, s_timeout); end
        n_run++; if (s_plot != 72) begin n_fail++; $display("FAIL pe_plots: got %0d want 72", s_plot); end
        n_run++; if (s_first_idx != 2) begin n_fail++; $display("FAIL pe_gap: first plot at sample %0d want 2 (one idle cycle)", s_first_idx); end
        n_run++; if (s_minx !== 8'd50 || s_maxx !== 8'd73) begin n_fail++; $display("FAIL pe_xspan: got %0d..%0d want 50..73", s_minx, s_maxx); end
        n_run++; if (s_miny !== 7'd112 || s_maxy !== 7'd114) begin n_fail++; $display("FAIL pe_yspan: got %0d..%0d want 112..114", s_miny, s_maxy); end
        n_run++; if (s_fcol !== 3'b000 || s_mixcol) begin n_fail++; $display("FAIL pe_colour: got %b mixed=%0b want 000", s_fcol, s_mixcol); end
        cycle();
    endtask

    task automatic test_clip();
        paddle_x = 8'd150;
        run_cmd(5'd14, 200);
        ld_draw = 0;
        n_run++; if (s_timeout || s_busy != 72) begin n_fail++; $display("FAIL clip_busy_cycles: got %0d timeout=%0b want 72", s_busy, s_timeout); end
        n_run++; if (s_plot != 30) begin n_fail++; $display("FAIL clip_plots: got %0d want 30", s_plot); end
        n_run++; if (s_minx !== 8'd150 || s_maxx !== 8'd159) begin n_fail++; $display("FAIL clip_xspan: got %0d..%0d want 150..159", s_minx, s_maxx); end
        n_run++; if (s_fcol !== 3'b111 || s_mixcol) begin n_fail++; $display("FAIL clip_colour: got %b mixed=%0b want 111", s_fcol, s_mixcol); end
        n_run++; if (s_done != 1) begin n_fail++; $display("FAIL clip_done_count: got %0d want 1", s_done); end
        cycle();
    endtask

    task automatic test_abort();
        bit saw_plot, saw_done, saw_busy;
        ball_x = 8'd20; ball_y = 7'd30;
        ld_draw = 5'd16;
        cycle();
        cycle();
        n_run++; if (plot !== 1'b1 || x !== 8'd20 || y !== 7'd30) begin n_fail++; $display("FAIL abort_first_px: got plot=%0b (%0d,%0d) want 1 (20,30)", plot, x, y); end
        ld_draw = 0;
        saw_plot = 0; saw_done = 0; saw_busy = 0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            if (plot) saw_plot = 1;
            if (done) saw_done = 1;
            #1;
            if (busy) saw_busy = 1;
        end
        n_run++; if (saw_plot) begin n_fail++; $display("FAIL abort_plot: got plot after abort want none"); end
        n_run++; if (saw_done) begin n_fail++; $display("FAIL abort_done: got done after abort want none"); end
        n_run++; if (saw_busy) begin n_fail++; $display("FAIL abort_busy: got busy=1 after abort want 0"); end
        cycle();
        run_cmd(5'd16, 20);
        ld_draw = 0;
        n_run++; if (s_fx !== 8'd20 || s_fy !== 7'd30 || s_first_idx != 2) begin n_fail++; $display("FAIL restart_first: got (%0d,%0d) at %0d want (20,30) at 2", s_fx, s_fy, s_first_idx); end
        n_run++; if (s_plot != 4 || s_done != 1) begin n_fail++; $display("FAIL restart_count: got plots=%0d done=%0d want 4 1", s_plot, s_done); end
        cycle();
    endtask

    task automatic test_noop();
        logic [4:0] codes [3];
        bit         bad;
        codes[0] = 5'd0; codes[1] = 5'd29; codes[2] = 5'd31;
        for (int k = 0; k < 3; k++) begin
            ld_draw = codes[k];
            bad = 0;
            for (int i = 0; i < 3; i++) begin
                #1;
                if (busy !== 1'b0) bad = 1;
                cycle();
                if (plot !== 1'b0) bad = 1;
            end
            n_run++; if (bad) begin n_fail++; $display("FAIL noop_%0d: got busy/plot activity want busy=0 plot=0", codes[k]); end
        end
        ld_draw = 0;
    endtask

    task automatic test_reset_mid();
        ld_draw = 5'd5;
        repeat (10) cycle();
        n_run++; if (plot !== 1'b1 || x === 8'd0) begin n_fail++; $display("FAIL midrst_running: got plot=%0b x=%0d want plot=1 x!=0", plot, x); end
        reset = 1;
        cycle();
        n_run++; if (x !== 8'd0 || y !== 7'd0 || colour !== 3'd0) begin n_fail++; $display("FAIL midrst_xyc: got (%0d,%0d) c=%b want (0,0) 000", x, y, colour); end
        n_run++; if (plot !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL midrst_plot_done: got %0b %0b want 0 0", plot, done); end
        reset = 0;
        ld_draw = 0;
        cycle(); cycle();
        #1;
        n_run++; if (busy !== 1'b0 || plot !== 1'b0) begin n_fail++; $display("FAIL midrst_idle: got busy=%0b plot=%0b want 0 0", busy, plot); end
    endtask

    initial begin
        test_reset();
        test_brick1();
        test_back_to_back();
        test_clip();
        test_abort();
        test_noop();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded 200000 ns");
        $fatal(1, "watchdog");
    end

endmodule
